// File: rtl/stage_sequencer_pkg.sv
// Shared encodings for the stage sequencer and the control unit that decodes its tick.
// Holds the one-hot stage strobes, the next-PC select codes and the FSM state type.
package stage_sequencer_pkg;

    localparam int unsigned TICK_W  = 5;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PCE_W   = 3;
    localparam int unsigned OFFS_W  = 8;

    // One-hot stage strobes; IDLE is all zeros so the control unit sees no stage.
    localparam logic [TICK_W-1:0] TICK_IDLE   = 5'b00000;
    localparam logic [TICK_W-1:0] TICK_FETCH  = 5'b10000;
    localparam logic [TICK_W-1:0] TICK_DECODE = 5'b01000;
    localparam logic [TICK_W-1:0] TICK_EXEC   = 5'b00100;
    localparam logic [TICK_W-1:0] TICK_MEM    = 5'b00010;
    localparam logic [TICK_W-1:0] TICK_WB     = 5'b00001;

    localparam logic [PCE_W-1:0] PCE_HOLD   = 3'b000;
    localparam logic [PCE_W-1:0] PCE_JUMP   = 3'b001;
    localparam logic [PCE_W-1:0] PCE_INC    = 3'b010;
    localparam logic [PCE_W-1:0] PCE_BRANCH = 3'b100;

    // State encoding equals the tick encoding, so the state register is the tick output.
    typedef enum logic [TICK_W-1:0] {
        ST_IDLE   = TICK_IDLE,
        ST_FETCH  = TICK_FETCH,
        ST_DECODE = TICK_DECODE,
        ST_EXEC   = TICK_EXEC,
        ST_MEM    = TICK_MEM,
        ST_WB     = TICK_WB
    } state_t;

    function automatic logic pce_is_legal(input logic [PCE_W-1:0] code);
        logic legal;
        legal = 1'b0;
        case (code)
            PCE_HOLD, PCE_JUMP, PCE_INC, PCE_BRANCH: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/stage_sequencer_pc_next.sv
// Combinational next-PC selection from the control unit's PC_enables verdict.
// Illegal select codes fall back to pc+1 and are flagged to the caller.
module pc_next_calc
    import stage_sequencer_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic [PCE_W-1:0]    pc_enables,
    output logic [PC_WIDTH-1:0] pc_next_c,
    output logic                illegal_c
);

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] branch_offs;
    logic [PC_WIDTH-1:0] branch_tgt;
    logic [PC_WIDTH-1:0] jump_tgt;
    logic [INSTR_W-1:0]  offs_ext;

    // 16-bit sign extension covers every legal PC_WIDTH; truncation gives modulo wrap.
    assign offs_ext    = {{(INSTR_W-OFFS_W){instruction[OFFS_W-1]}}, instruction[OFFS_W-1:0]};
    assign branch_offs = PC_WIDTH'(offs_ext);
    assign pc_inc      = pc + PC_WIDTH'(1);
    assign branch_tgt  = pc_inc + branch_offs;
    assign jump_tgt    = PC_WIDTH'(instruction);

    always_comb begin
        pc_next_c = pc_inc;
        illegal_c = !pce_is_legal(pc_enables);
        case (pc_enables)
            PCE_HOLD:   pc_next_c = pc;
            PCE_JUMP:   pc_next_c = jump_tgt;
            PCE_INC:    pc_next_c = pc_inc;
            PCE_BRANCH: pc_next_c = branch_tgt;
            default:    pc_next_c = pc_inc;
        endcase
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, fetches and holds the instruction,
// and drives the one-hot stage tick through FETCH/DECODE/EXEC/MEM/WB.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                mem_ready,
    input  logic [INSTR_W-1:0]  instr_mem_data,
    input  logic [PCE_W-1:0]    PC_enables,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_req,
    output logic [TICK_W-1:0]   tick,
    output logic [INSTR_W-1:0]  instruction,
    output logic                retired,
    output logic                pc_en_err
);

    state_t state;
    state_t next_state;

    logic [PC_WIDTH-1:0] pc_d;
    logic [INSTR_W-1:0]  instruction_d;
    logic                fetch_req_d;
    logic                retired_d;
    logic                pc_en_err_d;

    logic [PC_WIDTH-1:0] pc_next_c;
    logic                illegal_c;

    pc_next_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next (
        .pc          (pc),
        .instruction (instruction),
        .pc_enables  (PC_enables),
        .pc_next_c   (pc_next_c),
        .illegal_c   (illegal_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stage progression; once fetched, an instruction always runs through WB.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (enable) next_state = ST_FETCH;
            ST_FETCH:  if (mem_ready) next_state = ST_DECODE;
            ST_DECODE: next_state = ST_EXEC;
            ST_EXEC:   next_state = ST_MEM;
            ST_MEM:    next_state = ST_WB;
            ST_WB:     next_state = enable ? ST_FETCH : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d          = pc;
        instruction_d = instruction;
        retired_d     = 1'b0;
        pc_en_err_d   = pc_en_err;
        fetch_req_d   = (next_state == ST_FETCH);
        case (state)
            ST_FETCH: begin
                if (mem_ready) instruction_d = instr_mem_data;
            end
            ST_WB: begin
                pc_d        = pc_next_c;
                retired_d   = 1'b1;
                pc_en_err_d = pc_en_err | illegal_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            instruction <= '0;
            fetch_req   <= 1'b0;
            retired     <= 1'b0;
            pc_en_err   <= 1'b0;
        end else begin
            pc          <= pc_d;
            instruction <= instruction_d;
            fetch_req   <= fetch_req_d;
            retired     <= retired_d;
            pc_en_err   <= pc_en_err_d;
        end
    end

    assign tick = state;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: stimulus queues the expected retire state,
// a negedge monitor checks it whenever retired pulses.
module tb_stage_sequencer;
    import stage_sequencer_pkg::*;

    localparam int unsigned PC_WIDTH = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic                mem_ready = 1'b0;
    logic [INSTR_W-1:0]  instr_mem_data = '0;
    logic [PCE_W-1:0]    pce = '0;
    logic [PC_WIDTH-1:0] pc;
    logic                fetch_req;
    logic [TICK_W-1:0]   tick;
    logic [INSTR_W-1:0]  instruction;
    logic                retired;
    logic                pc_en_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PC_WIDTH-1:0] pc;
        logic                err;
        logic [INSTR_W-1:0]  instr;
        logic [TICK_W-1:0]   tick;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [PC_WIDTH-1:0] cur_pc = '0;
    logic                cur_err = 1'b0;

    stage_sequencer #(
        .PC_WIDTH (PC_WIDTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .mem_ready      (mem_ready),
        .instr_mem_data (instr_mem_data),
        .PC_enables     (pce),
        .pc             (pc),
        .fetch_req      (fetch_req),
        .tick           (tick),
        .instruction    (instruction),
        .retired        (retired),
        .pc_en_err      (pc_en_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (tick !== TICK_FETCH && n < 20) begin
            step();
            n++;
        end
        if (tick !== TICK_FETCH) chk("fetch_timeout", 32'(tick), 32'(TICK_FETCH));
    endtask

    // One instruction through all stages; junk on mem/PC_enables outside FETCH/WB must be ignored.
    task automatic run_instr(input logic [15:0] word, input logic [2:0] code, input int stalls,
                             input logic [7:0] exp_pc, input logic exp_err, input bit drop);
        exp_t e;
        e.pc = exp_pc;
        e.err = exp_err;
        e.instr = word;
        e.tick = drop ? TICK_IDLE : TICK_FETCH;
        exp_q.push_back(e);
        wait_fetch();
        chk("fetch_req", 32'(fetch_req), 32'd1);
        chk("pc_at_fetch", 32'(pc), 32'(cur_pc));
        mem_ready = 1'b0;
        instr_mem_data = 16'hDEAD;
        for (int i = 0; i < stalls; i++) begin
            step();
            chk("stall_tick", 32'(tick), 32'(TICK_FETCH));
        end
        mem_ready = 1'b1;
        instr_mem_data = word;
        step();
        chk("decode_tick", 32'(tick), 32'(TICK_DECODE));
        chk("instr_latched", 32'(instruction), 32'(word));
        instr_mem_data = 16'hBEEF;
        pce = 3'b111;
        step();
        chk("exec_tick", 32'(tick), 32'(TICK_EXEC));
        if (drop) enable = 1'b0;
        step();
        chk("mem_tick", 32'(tick), 32'(TICK_MEM));
        step();
        chk("wb_tick", 32'(tick), 32'(TICK_WB));
        chk("pc_stable_wb", 32'(pc), 32'(cur_pc));
        chk("instr_stable_wb", 32'(instruction), 32'(word));
        chk("err_before_wb", 32'(pc_en_err), 32'(cur_err));
        pce = code;
        mem_ready = 1'b0;
        step();
        pce = 3'b111;
        cur_pc = exp_pc;
        cur_err = exp_err;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && retired === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("retire_pc", 32'(pc), 32'(mon_e.pc));
                chk("retire_err", 32'(pc_en_err), 32'(mon_e.err));
                chk("retire_instr", 32'(instruction), 32'(mon_e.instr));
                chk("retire_tick", 32'(tick), 32'(mon_e.tick));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_tick", 32'(tick), 32'(TICK_IDLE));
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_err", 32'(pc_en_err), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_fetch_req", 32'(fetch_req), 32'd0);
        step();
        rst_n = 1'b1;
        enable = 1'b1;

        run_instr(16'h1111, PCE_INC,    0, 8'h01, 1'b0, 1'b0);
        run_instr(16'h2222, PCE_INC,    2, 8'h02, 1'b0, 1'b0);
        run_instr(16'h3333, PCE_INC,    0, 8'h03, 1'b0, 1'b0);
        run_instr(16'h0010, PCE_JUMP,   0, 8'h10, 1'b0, 1'b0);
        run_instr(16'hA0FC, PCE_BRANCH, 0, 8'h0D, 1'b0, 1'b0);
        run_instr(16'h00FF, PCE_JUMP,   1, 8'hFF, 1'b0, 1'b0);
        run_instr(16'h4444, PCE_INC,    0, 8'h00, 1'b0, 1'b0);
        run_instr(16'hF123, PCE_JUMP,   0, 8'h23, 1'b0, 1'b0);
        run_instr(16'h5555, PCE_HOLD,   0, 8'h23, 1'b0, 1'b0);
        run_instr(16'h6666, 3'b110,     0, 8'h24, 1'b1, 1'b0);
        run_instr(16'h7777, PCE_INC,    0, 8'h25, 1'b1, 1'b1);

        repeat (3) step();
        chk("idle_tick", 32'(tick), 32'(TICK_IDLE));
        chk("idle_fetch_req", 32'(fetch_req), 32'd0);
        chk("idle_pc", 32'(pc), 32'h25);
        chk("idle_err_sticky", 32'(pc_en_err), 32'd1);

        // Reset during DECODE discards the instruction with no retire and no PC update.
        enable = 1'b1;
        wait_fetch();
        mem_ready = 1'b1;
        instr_mem_data = 16'h8888;
        step();
        chk("pre_rst_tick", 32'(tick), 32'(TICK_DECODE));
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_rst_tick", 32'(tick), 32'(TICK_IDLE));
        chk("async_rst_pc", 32'(pc), 32'd0);
        chk("async_rst_instr", 32'(instruction), 32'd0);
        chk("async_rst_err", 32'(pc_en_err), 32'd0);
        chk("async_rst_retired", 32'(retired), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_tick", 32'(tick), 32'(TICK_IDLE));
        chk("post_rst_pc", 32'(pc), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
